// File: rtl/glide_pkg.sv
// Shared types and default sizes for the portamento note controller.
package glide_pkg;

    localparam int DEPTH_DEF = 4;
    localparam int FW_DEF    = 16;
    localparam int DIVW_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        GLIDE,
        HOLD
    } state_t;

    typedef struct packed {
        logic [6:0]        id;
        logic [FW_DEF-1:0] freq;
    } key_entry_t;

endpackage

// File: rtl/glide_ctrl_if.sv
// Key-event inputs, glide configuration and glide-unit connections of glide_ctrl.
interface glide_ctrl_if #(
    parameter int FW   = glide_pkg::FW_DEF,
    parameter int DIVW = glide_pkg::DIVW_DEF
);
    logic            key_valid;
    logic            key_down;
    logic [6:0]      key_id;
    logic [FW-1:0]   key_freq;
    logic            porta_on;
    logic            legato;
    logic [DIVW-1:0] rate_div;
    logic [FW-1:0]   step_size;
    logic [FW-1:0]   glide_out;
    logic [FW-1:0]   target_freq;
    logic [FW-1:0]   start_freq;
    logic            key_on;
    logic            glide_en;
    logic [FW-1:0]   glider;
    logic            gate;
    logic            busy;

    modport master (
        output key_valid, key_down, key_id, key_freq, porta_on, legato,
               rate_div, step_size, glide_out,
        input  target_freq, start_freq, key_on, glide_en, glider, gate, busy
    );

    modport slave (
        input  key_valid, key_down, key_id, key_freq, porta_on, legato,
               rate_div, step_size, glide_out,
        output target_freq, start_freq, key_on, glide_en, glider, gate, busy
    );
endinterface

// File: rtl/glide_rate_div.sv
// Free-running step prescaler: one-cycle tick every rate_div+1 cycles.
module glide_rate_div #(
    parameter int DIVW = glide_pkg::DIVW_DEF
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [DIVW-1:0] rate_div,
    output logic            tick
);
    logic [DIVW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            count <= '0;
        end else if (count >= rate_div) begin
            // A rate_div written below the running count wraps immediately.
            count <= '0;
        end else begin
            count <= count + DIVW'(1);
        end
    end

    assign tick = (count == rate_div);
endmodule

// File: rtl/glide_ctrl.sv
// Monophonic last-note-priority controller sequencing a portamento glide unit.
// Stack entries use glide_pkg::key_entry_t, so FW must equal glide_pkg::FW_DEF.
module glide_ctrl
    import glide_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int FW    = FW_DEF,
    parameter int DIVW  = DIVW_DEF
) (
    input  logic        CLK,
    input  logic        RESET,
    glide_ctrl_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    key_entry_t    stack_q [DEPTH];
    key_entry_t    stack_d [DEPTH];
    logic [CW-1:0] count_q, count_d;
    state_t        state_q, state_d;
    logic [FW-1:0] target_q, target_d;
    logic [FW-1:0] start_q, start_d;
    logic [FW-1:0] glider_q;
    logic [FW-1:0] new_target, new_start;
    logic          en_q;
    logic          tick;
    logic          hit;
    logic [IW-1:0] hit_idx;
    logic          retarget;
    logic          go_idle;

    glide_rate_div #(.DIVW(DIVW)) u_rate_div (
        .CLK      (CLK),
        .RESET    (RESET),
        .rate_div (bus.rate_div),
        .tick     (tick)
    );

    // NOTE: each always_comb assigns every output a default first, so no path can infer a latch.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (CW'(i) < count_q && stack_q[i].id == bus.key_id) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
        end
    end

    always_comb begin
        stack_d    = stack_q;
        count_d    = count_q;
        retarget   = 1'b0;
        go_idle    = 1'b0;
        new_target = bus.key_freq;
        new_start  = bus.glide_out;
        if (bus.key_valid && bus.key_down) begin
            // A re-pressed key only shifts the entries above it; a new key shifts the whole stack.
            for (int i = DEPTH - 1; i > 0; i--) begin
                if (!hit || IW'(i) <= hit_idx) stack_d[i] = stack_q[i-1];
            end
            stack_d[0] = '{id: bus.key_id, freq: bus.key_freq};
            if (!hit && count_q != CW'(DEPTH)) count_d = count_q + CW'(1);
            retarget = 1'b1;
            if (count_q == '0 && bus.legato) new_start = bus.key_freq;
        end else if (bus.key_valid && hit) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (IW'(i) >= hit_idx) stack_d[i] = stack_q[i+1];
            end
            count_d = count_q - CW'(1);
            if (count_q == CW'(1)) begin
                go_idle = 1'b1;
            end else if (hit_idx == '0) begin
                retarget   = 1'b1;
                new_target = stack_q[1].freq;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        start_d  = start_q;
        if (go_idle) begin
            state_d = IDLE;
        end else if (retarget) begin
            state_d  = LOAD;
            target_d = new_target;
            start_d  = new_start;
        end else begin
            case (state_q)
                LOAD:    state_d = GLIDE;
                GLIDE:   if (bus.glide_out == target_q) state_d = HOLD;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= IDLE;
            count_q  <= '0;
            target_q <= '0;
            start_q  <= '0;
            glider_q <= '0;
            en_q     <= 1'b0;
            // NOTE: the stack is a few flops, so it is cleared with everything else; count_q alone gates validity.
            for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            target_q <= target_d;
            start_q  <= start_d;
            stack_q  <= stack_d;
            glider_q <= (state_q == GLIDE && tick && !retarget && !go_idle) ? bus.step_size : '0;
            en_q     <= bus.porta_on;
        end
    end

    assign bus.target_freq = target_q;
    assign bus.start_freq  = start_q;
    assign bus.glider      = glider_q;
    assign bus.glide_en    = en_q;
    assign bus.key_on      = (state_q == GLIDE) || (state_q == HOLD);
    assign bus.busy        = (state_q == GLIDE);
    assign bus.gate        = (count_q != '0);
endmodule

// File: tb/tb_glide_ctrl.sv
// Directed and randomized checks of glide_ctrl against a queue-based note model.
module tb_glide_ctrl;
    localparam int FW    = 16;
    localparam int DIVW  = 16;
    localparam int DEPTH = 4;

    localparam int PH_IDLE  = 0;
    localparam int PH_LOAD  = 1;
    localparam int PH_GLIDE = 2;
    localparam int PH_HOLD  = 3;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;
    always #5 CLK = ~CLK;

    glide_ctrl_if #(.FW(FW), .DIVW(DIVW)) bus ();

    glide_ctrl #(.DEPTH(DEPTH), .FW(FW), .DIVW(DIVW)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: held keys as a newest-first queue, phase as a plain integer.
    typedef struct {
        int            id;
        logic [FW-1:0] freq;
    } held_t;

    held_t         held[$];
    int            m_phase  = PH_IDLE;
    int            m_cnt    = 0;
    logic [FW-1:0] m_target = '0;
    logic [FW-1:0] m_start  = '0;
    logic [FW-1:0] m_glider = '0;
    logic          m_en     = 1'b0;
    logic          m_key_on = 1'b0;
    logic          m_busy   = 1'b0;
    logic          m_gate   = 1'b0;

    always @(posedge CLK or negedge RESET) begin
        bit tick_now, ev, was_empty;
        int idx, old_phase;
        if (!RESET) begin
            held.delete();
            m_phase  = PH_IDLE;
            m_cnt    = 0;
            m_target = '0;
            m_start  = '0;
            m_glider = '0;
            m_en     = 1'b0;
        end else begin
            old_phase = m_phase;
            tick_now  = (m_cnt == int'(bus.rate_div));
            m_cnt     = (m_cnt >= int'(bus.rate_div)) ? 0 : m_cnt + 1;
            ev        = 1'b0;
            idx       = -1;
            foreach (held[i]) if (held[i].id == int'(bus.key_id)) idx = i;
            if (bus.key_valid && bus.key_down) begin
                was_empty = (held.size() == 0);
                if (idx >= 0) held.delete(idx);
                else if (held.size() == DEPTH) held.delete(DEPTH - 1);
                held.push_front('{id: int'(bus.key_id), freq: bus.key_freq});
                m_target = bus.key_freq;
                m_start  = (was_empty && bus.legato) ? bus.key_freq : bus.glide_out;
                m_phase  = PH_LOAD;
                ev       = 1'b1;
            end else if (bus.key_valid && idx >= 0) begin
                held.delete(idx);
                if (held.size() == 0) begin
                    m_phase = PH_IDLE;
                    ev      = 1'b1;
                end else if (idx == 0) begin
                    m_target = held[0].freq;
                    m_start  = bus.glide_out;
                    m_phase  = PH_LOAD;
                    ev       = 1'b1;
                end
            end
            m_glider = (old_phase == PH_GLIDE && tick_now && !ev) ? bus.step_size : '0;
            if (!ev) begin
                if (old_phase == PH_LOAD) m_phase = PH_GLIDE;
                else if (old_phase == PH_GLIDE && bus.glide_out == m_target) m_phase = PH_HOLD;
            end
            m_en = bus.porta_on;
        end
        m_key_on = (m_phase == PH_GLIDE) || (m_phase == PH_HOLD);
        m_busy   = (m_phase == PH_GLIDE);
        m_gate   = (held.size() != 0);
    end

    task automatic next_cycle();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic key_event(input bit down, input int id, input logic [FW-1:0] f);
        bus.key_valid = 1'b1;
        bus.key_down  = down;
        bus.key_id    = 7'(id);
        bus.key_freq  = f;
        next_cycle();
        bus.key_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [3*FW+3:0] all_out;
        bus.key_valid = 1'b0;
        bus.key_down  = 1'b0;
        bus.key_id    = '0;
        bus.key_freq  = '0;
        bus.porta_on  = 1'b1;
        bus.legato    = 1'b1;
        bus.rate_div  = 16'd3;
        bus.step_size = 16'h0010;
        bus.glide_out = 16'h0ABC;
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
        all_out = {bus.target_freq, bus.start_freq, bus.glider,
                   bus.key_on, bus.glide_en, bus.gate, bus.busy};
        n_cmp++;
        if (all_out !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 0", all_out);
        end
        RESET = 1'b1;
        next_cycle();
        n_cmp++;
        if (bus.glide_en !== 1'b1) begin
            n_bad++;
            $display("FAIL glide_en_latency: got %b want 1", bus.glide_en);
        end
    endtask

    task automatic test_first_press();
        key_event(1'b1, 60, 16'h1000);
        n_cmp++;
        if ({bus.target_freq, bus.start_freq, bus.key_on, bus.gate} !== {16'h1000, 16'h1000, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL press_load: got tgt=%h start=%h key_on=%b gate=%b want 1000 1000 0 1",
                     bus.target_freq, bus.start_freq, bus.key_on, bus.gate);
        end
        next_cycle();
        n_cmp++;
        if ({bus.key_on, bus.busy} !== 2'b11) begin
            n_bad++;
            $display("FAIL press_glide: got key_on=%b busy=%b want 1 1", bus.key_on, bus.busy);
        end
        bus.glide_out = 16'h1000;
        next_cycle();
        n_cmp++;
        if ({bus.key_on, bus.busy} !== 2'b10) begin
            n_bad++;
            $display("FAIL press_hold: got key_on=%b busy=%b want 1 0", bus.key_on, bus.busy);
        end
    endtask

    task automatic test_glide_rate();
        int n_steps, last_pos;
        bus.rate_div  = 16'd3;
        bus.step_size = 16'h0010;
        key_event(1'b1, 64, 16'h1400);
        n_cmp++;
        if ({bus.start_freq, bus.target_freq} !== {16'h1000, 16'h1400}) begin
            n_bad++;
            $display("FAIL second_press: got start=%h tgt=%h want 1000 1400", bus.start_freq, bus.target_freq);
        end
        next_cycle();
        n_steps  = 0;
        last_pos = -1;
        for (int k = 0; k < 12; k++) begin
            next_cycle();
            n_cmp++;
            if (bus.glider !== m_glider || (bus.glider !== 16'h0 && bus.glider !== 16'h0010)) begin
                n_bad++;
                $display("FAIL glider_pace k=%0d: got %h want %h", k, bus.glider, m_glider);
            end
            if (bus.glider !== 16'h0) begin
                if (last_pos >= 0 && k - last_pos != 4) begin
                    n_bad++;
                    $display("FAIL glider_spacing: got gap %0d want 4", k - last_pos);
                end
                last_pos = k;
                n_steps++;
            end
        end
        n_cmp++;
        if (n_steps != 3 || bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL glider_count: got %0d steps busy=%b want 3 steps busy=1", n_steps, bus.busy);
        end
    endtask

    task automatic test_release();
        bus.glide_out = 16'h1200;
        key_event(1'b0, 64, 16'h0);
        n_cmp++;
        if ({bus.target_freq, bus.start_freq, bus.key_on, bus.busy, bus.gate} !==
            {16'h1000, 16'h1200, 1'b0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL release_top: got tgt=%h start=%h key_on=%b busy=%b gate=%b want 1000 1200 0 0 1",
                     bus.target_freq, bus.start_freq, bus.key_on, bus.busy, bus.gate);
        end
        next_cycle();
        key_event(1'b0, 60, 16'h0);
        n_cmp++;
        if ({bus.target_freq, bus.key_on, bus.gate, bus.busy} !== {16'h1000, 1'b0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL release_last: got tgt=%h key_on=%b gate=%b busy=%b want 1000 0 0 0",
                     bus.target_freq, bus.key_on, bus.gate, bus.busy);
        end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 5; i++) begin
            key_event(1'b1, i, 16'(i * 'h100));
            next_cycle();
        end
        bus.glide_out = 16'h0777;
        key_event(1'b0, 5, 16'h0);
        n_cmp++;
        if ({bus.target_freq, bus.start_freq} !== {16'h0400, 16'h0777}) begin
            n_bad++;
            $display("FAIL overflow_release5: got tgt=%h start=%h want 0400 0777", bus.target_freq, bus.start_freq);
        end
        bus.glide_out = 16'h0400;
        repeat (2) next_cycle();
        key_event(1'b0, 1, 16'h0);
        n_cmp++;
        if ({bus.target_freq, bus.start_freq, bus.key_on, bus.busy, bus.gate} !==
            {16'h0400, 16'h0777, 1'b1, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL release_absent: got tgt=%h start=%h key_on=%b busy=%b gate=%b want 0400 0777 1 0 1",
                     bus.target_freq, bus.start_freq, bus.key_on, bus.busy, bus.gate);
        end
        key_event(1'b0, 4, 16'h0);
        n_cmp++;
        if (bus.target_freq !== 16'h0300) begin
            n_bad++;
            $display("FAIL release4_retarget: got %h want 0300", bus.target_freq);
        end
        key_event(1'b0, 3, 16'h0);
        key_event(1'b0, 2, 16'h0);
        n_cmp++;
        if (bus.gate !== 1'b0) begin
            n_bad++;
            $display("FAIL oldest_discarded: got gate=%b want 0", bus.gate);
        end
    endtask

    task automatic test_async_reset();
        logic [3*FW+3:0] all_out;
        bus.glide_out = 16'h0;
        bus.legato    = 1'b0;
        key_event(1'b1, 20, 16'h2000);
        next_cycle();
        n_cmp++;
        if ({bus.busy, bus.start_freq} !== {1'b1, 16'h0000}) begin
            n_bad++;
            $display("FAIL pre_reset_glide: got busy=%b start=%h want 1 0000", bus.busy, bus.start_freq);
        end
        @(posedge CLK);
        #2 RESET = 1'b0;
        #1;
        all_out = {bus.target_freq, bus.start_freq, bus.glider,
                   bus.key_on, bus.glide_en, bus.gate, bus.busy};
        n_cmp++;
        if (all_out !== '0) begin
            n_bad++;
            $display("FAIL async_reset: got %h want 0", all_out);
        end
        @(negedge CLK);
        RESET = 1'b1;
        next_cycle();
        n_cmp++;
        if ({bus.key_on, bus.busy, bus.gate, bus.target_freq} !== {3'b000, 16'h0000}) begin
            n_bad++;
            $display("FAIL post_reset_idle: got key_on=%b busy=%b gate=%b tgt=%h want 0 0 0 0000",
                     bus.key_on, bus.busy, bus.gate, bus.target_freq);
        end
    endtask

    task automatic test_coincide();
        bus.rate_div  = 16'd0;
        bus.step_size = 16'h0010;
        bus.legato    = 1'b1;
        bus.glide_out = 16'h0;
        key_event(1'b1, 10, 16'h0500);
        next_cycle();
        next_cycle();
        n_cmp++;
        if (bus.glider !== 16'h0010) begin
            n_bad++;
            $display("FAIL every_cycle_tick: got %h want 0010", bus.glider);
        end
        bus.glide_out = 16'h0500;
        key_event(1'b1, 11, 16'h0600);
        n_cmp++;
        if ({bus.key_on, bus.busy, bus.glider, bus.target_freq, bus.start_freq} !==
            {1'b0, 1'b0, 16'h0000, 16'h0600, 16'h0500}) begin
            n_bad++;
            $display("FAIL event_wins: got key_on=%b busy=%b glider=%h tgt=%h start=%h want 0 0 0000 0600 0500",
                     bus.key_on, bus.busy, bus.glider, bus.target_freq, bus.start_freq);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            n_cmp++;
            if (bus.target_freq !== m_target) begin
                n_bad++;
                $display("FAIL rnd_target c=%0d: got %h want %h", c, bus.target_freq, m_target);
            end
            n_cmp++;
            if (bus.start_freq !== m_start) begin
                n_bad++;
                $display("FAIL rnd_start c=%0d: got %h want %h", c, bus.start_freq, m_start);
            end
            n_cmp++;
            if (bus.glider !== m_glider) begin
                n_bad++;
                $display("FAIL rnd_glider c=%0d: got %h want %h", c, bus.glider, m_glider);
            end
            n_cmp++;
            if ({bus.key_on, bus.busy, bus.gate, bus.glide_en} !== {m_key_on, m_busy, m_gate, m_en}) begin
                n_bad++;
                $display("FAIL rnd_flags c=%0d: got %b%b%b%b want %b%b%b%b", c,
                         bus.key_on, bus.busy, bus.gate, bus.glide_en, m_key_on, m_busy, m_gate, m_en);
            end
            bus.key_valid = ($urandom_range(3) == 0);
            bus.key_down  = 1'($urandom_range(1));
            bus.key_id    = 7'($urandom_range(7));
            bus.key_freq  = 16'($urandom);
            bus.step_size = 16'($urandom_range(255));
            bus.glide_out = ($urandom_range(2) == 0) ? m_target : 16'($urandom);
            if ($urandom_range(15) == 0) bus.rate_div = 16'($urandom_range(5));
            if ($urandom_range(15) == 0) bus.porta_on = 1'($urandom_range(1));
            if ($urandom_range(7) == 0)  bus.legato   = 1'($urandom_range(1));
            next_cycle();
        end
        bus.key_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_press();
        test_glide_rate();
        test_release();
        test_overflow();
        test_async_reset();
        test_coincide();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/glide_ctrl.md
Name: glide_ctrl

Overview:
- Monophonic note controller that sequences the portamento (glide) datapath.
- Keeps a last-note-priority stack of held keys and drives the glide unit's target frequency, start frequency, key_on and enable.
- Generates the paced per-step glide increment from a programmable rate prescaler.
- Sits between the keyboard/MIDI event decoder and the glide unit. The glide unit's output is fed back so the controller can detect arrival at the target.

Parameters:
- DEPTH, 4, number of simultaneously held keys tracked (2..8)
- FW, 16, frequency word width
- DIVW, 16, prescaler width

Ports:
- CLK  in  1  system clock
- RESET  in  1  asynchronous, active-low reset
- key_valid  in  1  one-cycle key event strobe
- key_down  in  1  event type: 1 = press, 0 = release (qualified by key_valid)
- key_id  in  7  key number
- key_freq  in  FW  frequency word for key_id (press only)
- porta_on  in  1  portamento enable
- legato  in  1  1 = glide only when a key is already held
- rate_div  in  DIVW  step period in CLK cycles minus 1
- step_size  in  FW  glide increment per step
- glide_out  in  FW  current glide unit output (feedback)
- target_freq  out  FW  to glide unit "in"
- start_freq  out  FW  to glide unit "state"
- key_on  out  1  to glide unit key_on
- glide_en  out  1  to glide unit Enable
- glider  out  FW  to glide unit glider
- gate  out  1  envelope gate: 1 while any key is held
- busy  out  1  1 in GLIDE state

Behaviour:
- Reset (RESET=0, async):
  - All outputs are 0.
  - Stack is emptied, prescaler is 0, state is IDLE.
- States:
  - IDLE: stack empty. key_on=0, gate=0.
  - LOAD: one cycle with key_on=0, so the glide unit samples start_freq.
  - GLIDE: key_on=1. Moves to HOLD the first cycle glide_out==target_freq.
  - HOLD: key_on=1, glide complete.
- Stack:
  - Entries are {id, freq}; entry 0 is the newest.
  - Press of an id not in the stack: shift the stack down and write the new entry at 0. If the stack is full, the oldest entry is discarded.
  - Press of an id already in the stack: move that entry to the top with the new freq.
  - Release: remove the matching entry and compact. Release of an id not in the stack is ignored with no state change.
- Press event at cycle n, registered at n+1:
  - target_freq = key_freq, gate = 1, state = LOAD.
  - start_freq = glide_out if the stack was non-empty before the press.
  - If the stack was empty: start_freq = key_freq when legato=1; otherwise start_freq = glide_out.
  - At n+2: state = GLIDE, key_on = 1.
- Release at cycle n:
  - If the released entry was the top and the stack stays non-empty: retarget exactly as for a press of the new top (start = glide_out, state = LOAD).
  - If a non-top entry is released: no output change.
  - If the stack becomes empty: state = IDLE, key_on = 0, gate = 0 at n+1. target_freq holds its value.
- glide_en = porta_on, registered with 1-cycle latency. Deasserting it mid-glide makes the glide unit pass target through. State tracking is unaffected.
- Prescaler:
  - Free-running counter 0..rate_div. A tick is one cycle, asserted when count==rate_div, then the count wraps to 0.
  - rate_div=0 gives a tick every cycle.
  - Writing rate_div below the current count forces a wrap on the next cycle.
- glider = step_size on tick cycles in GLIDE, else 0 (registered).
- Simultaneous events:
  - A key event and a tick in the same cycle: the event wins and glider=0 that cycle.
  - A key event and arrival in the same cycle: the event wins (state = LOAD).
- step_size=0 in GLIDE: stays in GLIDE until glide_out==target. Not an error.
- Frequency words are unsigned. The controller performs no arithmetic on frequencies, only equality comparison.

Decomposition:
- Package glide_pkg: state enum {IDLE, LOAD, GLIDE, HOLD}, key entry struct {id[6:0], freq[FW-1:0]}, and DEPTH/FW defaults.
- Sub-module glide_rate_div: prescaler with rate_div input and tick output.
- Stack and FSM stay in glide_ctrl.

Test Plan:
1. Reset, then press id 60, freq 0x1000, legato=1 -> at n+1 target=start=0x1000, key_on=0; at n+2 key_on=1. When glide_out=0x1000 -> HOLD, busy=0.
2. Hold id 60 at 0x1000, glide_out=0x1000; press id 64, freq 0x1400, rate_div=3, step_size=0x10 -> start=0x1000, target=0x1400. glider=0x10 exactly every 4th cycle in GLIDE, 0 otherwise.
3. Hold 60 then 64; release 64 mid-glide with glide_out=0x1200 -> target=0x1000, start=0x1200, LOAD. Then release 60 -> key_on=0, gate=0, target stays 0x1000.
4. DEPTH=4: press ids 1..5 -> id 1 discarded. Release 5 -> target = freq(4). Release 1 -> no change.
5. Press a key, then assert RESET low mid-GLIDE, asynchronously and off the clock edge -> all outputs 0 immediately, IDLE after release.
6. Key event coinciding with a tick and with glide_out==target -> event wins: LOAD, glider=0 that cycle.
